// File: rtl/key_conditioner.sv
// Multi-channel push-button front end: synchroniser, debouncer, press/release
// pulses and hold-to-repeat ticks, one identical independent slice per key.
module key_conditioner #(
  parameter int N_KEYS          = 6,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic              pixel_clk,
  input  logic              sys_rst_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_repeat
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
  localparam logic             IDLE_RAW    = (ACTIVE_LOW != 0);
  localparam bit               RPT_EN      = (REPEAT_DELAY > 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT
  } rptState_t;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sample;
    logic [DB_W-1:0]        r_dbCnt;
    logic                   r_level;
    logic                   r_press;
    logic                   r_release;
    logic                   w_accept;
    logic                   w_acceptPress;
    logic                   w_acceptRelease;
    rptState_t              r_state;
    rptState_t              w_stateNext;
    logic [RPT_W-1:0]       r_rptCnt;
    logic [RPT_W-1:0]       w_rptCntNext;
    logic                   r_repeat;
    logic                   w_repeatNext;

    // Reset reloads the released pin level so no spurious press is seen.
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        r_sync <= {SYNC_STAGES{IDLE_RAW}};
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], key_in[i]};
      end
    end

    assign w_sample        = (ACTIVE_LOW != 0) ? ~r_sync[SYNC_STAGES-1] : r_sync[SYNC_STAGES-1];
    assign w_accept        = (w_sample != r_level) && (r_dbCnt == DB_LAST);
    assign w_acceptPress   = w_accept && !r_level;
    assign w_acceptRelease = w_accept && r_level;

    // Pulses are registered alongside the level so they land on its first new cycle.
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        r_dbCnt   <= '0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_press   <= w_acceptPress;
        r_release <= w_acceptRelease;
        if ((w_sample == r_level) || w_accept) begin
          r_dbCnt <= '0;
        end else if (r_dbCnt != '1) begin
          r_dbCnt <= r_dbCnt + DB_W'(1);
        end
        if (w_accept) begin
          r_level <= ~r_level;
        end
      end
    end

    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        r_state  <= ST_IDLE;
        r_rptCnt <= '0;
        r_repeat <= 1'b0;
      end else begin
        r_state  <= w_stateNext;
        r_rptCnt <= w_rptCntNext;
        r_repeat <= w_repeatNext;
      end
    end

    // A release overrides everything, which also kills a tick due on that edge.
    always_comb begin
      w_stateNext  = r_state;
      w_rptCntNext = r_rptCnt;
      w_repeatNext = 1'b0;
      if (w_acceptRelease) begin
        w_stateNext  = ST_IDLE;
        w_rptCntNext = '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_acceptPress && RPT_EN) begin
              w_stateNext  = ST_DELAY;
              w_rptCntNext = '0;
            end
          end
          ST_DELAY: begin
            if (r_rptCnt == DELAY_LAST) begin
              w_stateNext  = ST_REPEAT;
              w_rptCntNext = '0;
              w_repeatNext = 1'b1;
            end else begin
              w_rptCntNext = r_rptCnt + RPT_W'(1);
            end
          end
          ST_REPEAT: begin
            if (r_rptCnt == PERIOD_LAST) begin
              w_rptCntNext = '0;
              w_repeatNext = 1'b1;
            end else begin
              w_rptCntNext = r_rptCnt + RPT_W'(1);
            end
          end
          default: begin
            w_stateNext  = ST_IDLE;
            w_rptCntNext = '0;
          end
        endcase
      end
    end

    assign key_level[i]   = r_level;
    assign key_press[i]   = r_press;
    assign key_release[i] = r_release;
    assign key_repeat[i]  = r_repeat;
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: a timing-rule reference model queues the
// expected outputs for every clock edge and a negedge monitor compares them.
module tb_key_conditioner;

  localparam int N_KEYS = 6;
  localparam int SYNC   = 2;
  localparam int DEB    = 4;
  localparam int RDELAY = 10;
  localparam int RPER   = 5;

  typedef struct packed {
    logic [N_KEYS-1:0] lvl;
    logic [N_KEYS-1:0] prs;
    logic [N_KEYS-1:0] rls;
    logic [N_KEYS-1:0] rpt;
  } exp_t;

  logic              pixel_clk;
  logic              sys_rst_n;
  logic [N_KEYS-1:0] key_in;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] key_repeat;

  int tests    = 0;
  int failures = 0;
  int cycle    = 0;

  exp_t              expQ[$];
  logic [N_KEYS-1:0] rawHist[$];
  int                edgeIdx;
  int                runLen[N_KEYS];
  int                pressEdge[N_KEYS];
  logic [N_KEYS-1:0] lastS;
  logic [N_KEYS-1:0] mLevel;

  key_conditioner #(
    .N_KEYS(N_KEYS),
    .SYNC_STAGES(SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .ACTIVE_LOW(1),
    .REPEAT_DELAY(RDELAY),
    .REPEAT_PERIOD(RPER)
  ) dut (
    .pixel_clk(pixel_clk),
    .sys_rst_n(sys_rst_n),
    .key_in(key_in),
    .key_level(key_level),
    .key_press(key_press),
    .key_release(key_release),
    .key_repeat(key_repeat)
  );

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  // Reference model: a sample is the pressed state seen SYNC edges ago; the level
  // flips once a run of DEB identical samples disagrees with it; repeat ticks
  // fall at RDELAY + k*RPER edges after the press while the key stays down.
  always @(posedge pixel_clk) begin
    exp_t              e;
    logic [N_KEYS-1:0] s;
    int                d;
    e     = '0;
    cycle = cycle + 1;
    if (!sys_rst_n) begin
      rawHist.delete();
      edgeIdx = 0;
      mLevel  = '0;
      lastS   = '0;
      for (int k = 0; k < N_KEYS; k++) begin
        runLen[k]    = 0;
        pressEdge[k] = 0;
      end
    end else begin
      rawHist.push_back(~key_in);
      s = (edgeIdx >= SYNC) ? rawHist[edgeIdx - SYNC] : '0;
      for (int k = 0; k < N_KEYS; k++) begin
        if (s[k] == lastS[k]) begin
          runLen[k] = runLen[k] + 1;
        end else begin
          lastS[k]  = s[k];
          runLen[k] = 1;
        end
        if ((s[k] != mLevel[k]) && (runLen[k] >= DEB)) begin
          if (!mLevel[k]) begin
            e.prs[k]     = 1'b1;
            pressEdge[k] = edgeIdx;
          end else begin
            e.rls[k] = 1'b1;
          end
          mLevel[k] = ~mLevel[k];
        end else if (mLevel[k] && (RDELAY > 0)) begin
          d = edgeIdx - pressEdge[k];
          if ((d >= RDELAY) && (((d - RDELAY) % RPER) == 0)) begin
            e.rpt[k] = 1'b1;
          end
        end
      end
      edgeIdx = edgeIdx + 1;
    end
    e.lvl = mLevel;
    expQ.push_back(e);
  end

  task automatic checkOutput(input string name, input logic [N_KEYS-1:0] act,
                             input logic [N_KEYS-1:0] req);
    tests = tests + 1;
    if (act !== req) begin
      failures = failures + 1;
      $display("[TB] FAIL %s at cycle %0d: got %b, expected %b", name, cycle, act, req);
    end
  endtask

  always @(negedge pixel_clk) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("key_level", key_level, e.lvl);
      checkOutput("key_press", key_press, e.prs);
      checkOutput("key_release", key_release, e.rls);
      checkOutput("key_repeat", key_repeat, e.rpt);
    end
  end

  // Drives the raw pins, then lets n clock edges go by (returns just after an edge).
  task automatic applyStimulus(input logic [N_KEYS-1:0] raw, input int n);
    key_in = raw;
    repeat (n) @(posedge pixel_clk);
    #1;
  endtask

  // Reset moves only just after a negedge so the monitor never straddles it.
  task automatic pulseReset(input int n);
    @(negedge pixel_clk);
    #1 sys_rst_n = 1'b0;
    repeat (n) @(posedge pixel_clk);
    @(negedge pixel_clk);
    #1 sys_rst_n = 1'b1;
  endtask

  initial begin
    logic [N_KEYS-1:0] raw;
    int                holdLeft[N_KEYS];

    sys_rst_n = 1'b0;
    key_in    = '1;
    repeat (5) @(posedge pixel_clk);
    @(negedge pixel_clk);
    #1 sys_rst_n = 1'b1;
    applyStimulus(6'b111111, 100);

    $display("[TB] clean press on key 0");
    applyStimulus(6'b111110, 20);
    applyStimulus(6'b111111, 20);

    $display("[TB] bounce rejection on key 1");
    applyStimulus(6'b111101, 3);
    applyStimulus(6'b111111, 1);
    applyStimulus(6'b111101, 3);
    applyStimulus(6'b111111, 20);

    $display("[TB] hold-repeat on key 2");
    applyStimulus(6'b111011, 40);
    applyStimulus(6'b111111, 20);

    $display("[TB] simultaneous keys 3 and 5");
    applyStimulus(6'b010111, 8);
    applyStimulus(6'b011111, 30);
    applyStimulus(6'b111111, 20);

    $display("[TB] reset during repeat on key 4");
    applyStimulus(6'b101111, 25);
    pulseReset(3);
    applyStimulus(6'b101111, 30);
    applyStimulus(6'b111111, 20);

    $display("[TB] randomized traffic");
    raw = '1;
    for (int k = 0; k < N_KEYS; k++) holdLeft[k] = $urandom_range(1, 30);
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N_KEYS; k++) begin
        if (holdLeft[k] == 0) begin
          raw[k]      = ~raw[k];
          holdLeft[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4)
                                                    : $urandom_range(5, 40);
        end else begin
          holdLeft[k] = holdLeft[k] - 1;
        end
      end
      applyStimulus(raw, 1);
      if ($urandom_range(0, 499) == 0) pulseReset($urandom_range(1, 4));
    end
    applyStimulus('1, 30);

    repeat (2) @(negedge pixel_clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Parametrised multi-channel key front end between the board push-buttons and the snake game control logic, clocked on pixel_clk. Per channel it provides:
- a synchroniser and a consecutive-sample debouncer;
- a clean active-high level, plus one-cycle press and release pulses;
- a hold-to-repeat tick stream for held direction keys.

All channels are independent and identical.

## Interface
Parameters:
- N_KEYS, 6, number of independent key channels
- SYNC_STAGES, 2, synchroniser flops per channel (legal ≥2)
- DEBOUNCE_CYCLES, 1000000, consecutive disagreeing samples required to accept a change (10 ms at 100 MHz; legal ≥1)
- ACTIVE_LOW, 1, 1 = raw key reads 0 when pressed
- REPEAT_DELAY, 50000000, cycles from accepted press to first repeat tick; 0 disables repeat
- REPEAT_PERIOD, 10000000, cycles between subsequent repeat ticks (legal ≥1)

Ports (clock and reset first):
- pixel_clk  input  1  block clock
- sys_rst_n  input  1  reset, asynchronous, active-low
- key_in  input  N_KEYS  raw asynchronous key pins, polarity per ACTIVE_LOW
- key_level  output  N_KEYS  debounced level, 1 = pressed
- key_press  output  N_KEYS  one-cycle pulse when key_level rises
- key_release  output  N_KEYS  one-cycle pulse when key_level falls
- key_repeat  output  N_KEYS  one-cycle tick stream while held

## Operation
Reset:
- Sync chain reloads to the idle raw level: 1 if ACTIVE_LOW, else 0.
- All counters go to 0; all repeat FSMs go to IDLE.
- key_level, key_press, key_release and key_repeat are all 0.
- Reset asserted mid-operation aborts everything immediately and emits no pulses.

Synchroniser and polarity:
- key_in[i] passes through SYNC_STAGES flops.
- The last stage is inverted when ACTIVE_LOW=1, giving sampled s[i], where 1 = pressed.

Debounce:
- Per-channel counter, width $clog2(DEBOUNCE_CYCLES+1).
- Each cycle s[i] == key_level[i]: counter cleared to 0.
- Each cycle s[i] != key_level[i]: counter increments.
- When the counter reaches DEBOUNCE_CYCLES-1 on a disagreeing cycle, key_level[i] toggles and the counter clears on the same edge.
- Net effect: a change is accepted after exactly DEBOUNCE_CYCLES consecutive disagreeing samples.
- A single agreeing sample restarts the count, so glitches shorter than DEBOUNCE_CYCLES never reach key_level.
- The counter must saturate, never wrap.

Edges:
- key_press[i] and key_release[i] are registered.
- Each is high in exactly the single cycle in which key_level[i] holds its new value for the first time.

Repeat FSM (per channel):
- IDLE: on accepted press, go to DELAY with hold counter = 0. If REPEAT_DELAY=0, stay IDLE permanently (key_repeat tied 0).
- DELAY: counter increments each cycle. At count REPEAT_DELAY-1, pulse key_repeat, clear the counter and go to REPEAT.
- REPEAT: counter increments each cycle. At count REPEAT_PERIOD-1, pulse key_repeat and clear the counter.
- Any state: accepted release returns the FSM to IDLE with counter = 0 on the same edge as key_release. No repeat pulse is ever issued in the release cycle or afterwards.
- Counter width is $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1).
- key_press and key_repeat are never high in the same cycle for the same channel.

## Timing
- Raw edge to key_level change: SYNC_STAGES + DEBOUNCE_CYCLES cycles, for a raw level held stable.
- key_press and key_release coincide with the key_level change.
- First key_repeat: REPEAT_DELAY cycles after the key_press cycle.
- Later key_repeat ticks: every REPEAT_PERIOD cycles.
- Key held through reset release: the press is accepted SYNC_STAGES + DEBOUNCE_CYCLES cycles after deassertion, then key_press pulses normally.
- Simultaneous activity on several channels is fully independent. Any combination of pulses may be high in one cycle.
- No combinational path from key_in to any output.

## Test plan
Bench configuration: N_KEYS=6, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1, REPEAT_DELAY=10, REPEAT_PERIOD=5.

- Reset and idle: all key_in=1 through reset and 100 cycles → all outputs 0 throughout, no pulses after reset release.
- Clean press: key_in[0] 1→0 at cycle T and held → key_level[0]=1 and key_press[0]=1 at T+6; key_press[0]=0 at T+7.
- Bounce rejection: key_in[1] low for 3 cycles, high 1, low 3, high → key_level[1], key_press[1] and key_release[1] stay 0.
- Hold-repeat: key_in[2] low at T, held 40 cycles, then released → key_press at T+6; key_repeat at T+16, T+21, T+26, T+31, T+36, T+41. Release (raw high at T+40) gives key_release at T+46 with no further key_repeat. The T+46 tick must be suppressed.
- Multi-channel: key_in[3] and key_in[5] pressed on the same cycle, key_in[3] released 8 cycles later → both key_press pulses coincide; key_release[3] is unaffected by channel 5, which keeps repeating.
- Reset mid-hold: key_in[4] held low, sys_rst_n pulsed low for 3 cycles while in REPEAT → all outputs 0 immediately. After release of reset: key_press[4] 6 cycles later, first key_repeat 10 cycles after that.
